// File: rtl/controle_multiciclo.sv
// Multicycle main controller for the MIPS-subset datapath: Moore decode of the
// current state drives every mux select and write enable; fetch writes wait on MemReady.
module controle_multiciclo (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] entrada,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSource,
  output logic [3:0] estado
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExec     = 4'd6,
    StRtypeWb  = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;

  always_comb begin
    state_d = StFetch;
    op_d    = op_q;
    unique case (state_q)
      StFetch:    state_d = MemReady ? StDecode : StFetch;
      StDecode: begin
        op_d = entrada;
        unique case (entrada)
          OpRtype:     state_d = StExec;
          OpLw, OpSw:  state_d = StMemAddr;
          OpBeq:       state_d = StBranch;
          OpJ:         state_d = StJump;
          OpAddi:      state_d = StAddiExec;
          default:     state_d = StFetch;
        endcase
      end
      // Uses the opcode latched in DECODE; the live IR field is ignored here.
      StMemAddr: begin
        if (op_q == OpLw)      state_d = StMemRead;
        else if (op_q == OpSw) state_d = StMemWrite;
        else                   state_d = StFetch;
      end
      StMemRead:  state_d = MemReady ? StMemWb : StMemRead;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = MemReady ? StFetch : StMemWrite;
      StExec:     state_d = StRtypeWb;
      StRtypeWb:  state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJump:     state_d = StFetch;
      StAddiExec: state_d = StAddiWb;
      StAddiWb:   state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StFetch;
      op_q    <= 6'b000000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUsrcA     = 1'b0;
    ALUsrcB     = 2'b00;
    ALUop       = 2'b00;
    PCSource    = 2'b00;
    unique case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUsrcB = 2'b01;
        PCWrite = MemReady;
        IRWrite = MemReady;
      end
      StDecode:   ALUsrcB = 2'b11;
      StMemAddr: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
      end
      StMemRead: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      StMemWrite: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StExec: begin
        ALUsrcA = 1'b1;
        ALUop   = 2'b11;
      end
      StRtypeWb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      StBranch: begin
        ALUsrcA     = 1'b1;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      StAddiExec: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
      end
      StAddiWb:   RegWrite = 1'b1;
      default: ;
    endcase
    // Reset blocks every enable immediately, not just from the next edge.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemToReg    = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUsrcA     = 1'b0;
      ALUsrcB     = 2'b00;
      ALUop       = 2'b00;
      PCSource    = 2'b00;
    end
  end

  assign estado = state_q;

endmodule
